// File: rtl/box_filter_param.sv
// box_filter_param: raster-scan box filter with edge clamping
// and an optional adaptive-threshold output stage.
module box_filter_param #(
    parameter int WIDTH_BITS  = 8,
    parameter int HEIGHT_BITS = 8,
    parameter int RADIUS      = 1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   iStart,
    input  logic                   iMode,
    input  logic [7:0]             iOffset,
    output logic [WIDTH_BITS-1:0]  oImageCol,
    output logic [HEIGHT_BITS-1:0] oImageRow,
    input  logic [7:0]             iImageData,
    output logic [WIDTH_BITS-1:0]  oResultCol,
    output logic [HEIGHT_BITS-1:0] oResultRow,
    output logic [7:0]             oResultData,
    output logic                   oResultWren,
    output logic                   busy,
    output logic                   finished
);

    localparam int N     = 2 * RADIUS + 1;
    localparam int NSQ   = N * N;
    localparam int KW    = $clog2(N);
    localparam int ACC_W = 8 + $clog2(NSQ);
    localparam int RECIP = (65536 + NSQ - 1) / NSQ;
    localparam int PW    = ACC_W + 17;
    localparam int CW    = WIDTH_BITS + 5;
    localparam int RW    = HEIGHT_BITS + 5;

    localparam logic [KW-1:0] K_LAST = KW'(N - 1);
    localparam logic [KW-1:0] K_MID  = KW'(RADIUS);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        DRAIN,
        WRITE,
        DONE
    } stateType;

    stateType state;
    stateType nextState;

    logic [WIDTH_BITS-1:0]  col;
    logic [HEIGHT_BITS-1:0] row;
    logic [KW-1:0]          kx;
    logic [KW-1:0]          ky;
    logic [ACC_W-1:0]       sum;
    logic [7:0]             centre;
    logic [7:0]             offset;
    logic                   mode;
    logic                   sampleValid;
    logic                   sampleCentre;

    logic [CW-1:0]          colWide;
    logic [RW-1:0]          rowWide;
    logic [WIDTH_BITS-1:0]  clampCol;
    logic [HEIGHT_BITS-1:0] clampRow;
    logic [PW-1:0]          prod;
    logic [PW-1:0]          meanWide;
    logic [7:0]             mean;
    logic [7:0]             thr;
    logic [7:0]             pixOut;

    wire kLast   = (kx == K_LAST) && (ky == K_LAST);
    wire lastPix = (&col) && (&row);

    // State register; reset aborts a run immediately
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= nextState;
    end

    // Next-state logic
    always_comb begin
        nextState = state;
        unique case (state)
            IDLE, DONE: if (iStart) nextState = READ;
            READ:       if (kLast) nextState = DRAIN;
            DRAIN:      nextState = WRITE;
            WRITE:      nextState = lastPix ? DONE : READ;
            default:    nextState = IDLE;
        endcase
    end

    // Scan counters, window accumulator and latched run settings
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            col          <= '0;
            row          <= '0;
            kx           <= '0;
            ky           <= '0;
            sum          <= '0;
            centre       <= '0;
            offset       <= '0;
            mode         <= 1'b0;
            sampleValid  <= 1'b0;
            sampleCentre <= 1'b0;
        end else begin
            sampleValid  <= (state == READ);
            sampleCentre <= (state == READ) && (kx == K_MID) && (ky == K_MID);
            if (sampleValid) begin
                sum <= sum + ACC_W'(iImageData);
                if (sampleCentre) centre <= iImageData;
            end
            unique case (state)
                IDLE, DONE: begin
                    if (iStart) begin
                        mode   <= iMode;
                        offset <= iOffset;
                        col    <= '0;
                        row    <= '0;
                        kx     <= '0;
                        ky     <= '0;
                        sum    <= '0;
                    end
                end
                READ: begin
                    if (kx == K_LAST) begin
                        kx <= '0;
                        ky <= (ky == K_LAST) ? '0 : ky + 1'b1;
                    end else begin
                        kx <= kx + 1'b1;
                    end
                end
                WRITE: begin
                    sum <= '0;
                    col <= col + 1'b1;
                    if (&col) row <= row + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Window address with edge replication, mean and threshold datapath
    always_comb begin
        colWide = {5'b0, col} + CW'(kx) - CW'(RADIUS);
        rowWide = {5'b0, row} + RW'(ky) - RW'(RADIUS);
        if (colWide[CW-1])                   clampCol = '0;
        else if (|colWide[CW-2:WIDTH_BITS])  clampCol = '1;
        else                                 clampCol = colWide[WIDTH_BITS-1:0];
        if (rowWide[RW-1])                   clampRow = '0;
        else if (|rowWide[RW-2:HEIGHT_BITS]) clampRow = '1;
        else                                 clampRow = rowWide[HEIGHT_BITS-1:0];
        prod     = PW'(sum) * PW'(RECIP);
        meanWide = prod >> 16;
        mean     = (|meanWide[PW-1:8]) ? 8'hFF : meanWide[7:0];
        thr      = (mean > offset) ? mean - offset : 8'd0;
        pixOut   = mode ? ((centre > thr) ? 8'hFF : 8'h00) : mean;
    end

    // Port drive; addresses and data are zero outside their active states
    always_comb begin
        oImageCol   = '0;
        oImageRow   = '0;
        oResultData = '0;
        if (state == READ) begin
            oImageCol = clampCol;
            oImageRow = clampRow;
        end
        if (state == WRITE) oResultData = pixOut;
        oResultWren = (state == WRITE);
        oResultCol  = col;
        oResultRow  = row;
        busy        = (state == READ) || (state == DRAIN) || (state == WRITE);
        finished    = (state == DONE);
    end

endmodule

// File: tb/tb_box_filter_param.sv
// tb_box_filter_param: scoreboard bench for box_filter_param
// on a 4x4 image with a 3x3 kernel.
module tb_box_filter_param;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       iStart = 1'b0;
    logic       iMode = 1'b0;
    logic [7:0] iOffset = '0;
    logic [1:0] oImageCol, oImageRow;
    logic [7:0] iImageData = '0;
    logic [1:0] oResultCol, oResultRow;
    logic [7:0] oResultData;
    logic       oResultWren, busy, finished;

    typedef struct {
        logic [1:0] col;
        logic [1:0] row;
        logic [7:0] data;
    } expT;

    expT        sb[$];
    logic [7:0] rom    [16];
    logic [7:0] expImg [16];
    int         errors = 0;
    int         checks = 0;
    int         writes = 0;

    box_filter_param #(
        .WIDTH_BITS (2),
        .HEIGHT_BITS(2),
        .RADIUS     (1)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .iStart     (iStart),
        .iMode      (iMode),
        .iOffset    (iOffset),
        .oImageCol  (oImageCol),
        .oImageRow  (oImageRow),
        .iImageData (iImageData),
        .oResultCol (oResultCol),
        .oResultRow (oResultRow),
        .oResultData(oResultData),
        .oResultWren(oResultWren),
        .busy       (busy),
        .finished   (finished)
    );

    // Free-running clock
    always #5 clock = ~clock;

    // Behavioural synchronous ROM, one cycle of latency
    always @(posedge clock) iImageData <= rom[{oImageRow, oImageCol}];

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    // Monitor: every write strobe is compared with the next expected pixel
    always @(negedge clock) begin
        if (oResultWren) begin
            expT e;
            writes++;
            if (sb.size() == 0) begin
                check("unexpected_write", 1, 0);
            end else begin
                e = sb.pop_front();
                check("write_col", int'(oResultCol), int'(e.col));
                check("write_row", int'(oResultRow), int'(e.row));
                check("write_data", int'(oResultData), int'(e.data));
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic fillAll(input logic [7:0] v, input logic [7:0] e);
        for (int i = 0; i < 16; i++) begin
            rom[i]    = v;
            expImg[i] = e;
        end
    endtask

    task automatic pushExpected();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                expT e;
                e.col  = 2'(c);
                e.row  = 2'(r);
                e.data = expImg[r*4+c];
                sb.push_back(e);
            end
    endtask

    task automatic runPass(input logic m, input logic [7:0] off,
                           input int pokeAt);
        int cycles;
        pushExpected();
        writes  = 0;
        iMode   = m;
        iOffset = off;
        iStart  = 1'b1;
        tick();
        iStart  = 1'b0;
        iMode   = ~m;
        iOffset = ~off;
        check("start_busy", int'(busy), 1);
        check("start_finished", int'(finished), 0);
        cycles = 0;
        while (!finished && cycles < 400) begin
            iStart = (cycles == pokeAt);
            tick();
            cycles++;
        end
        iStart = 1'b0;
        check("run_length", cycles, 176);
        check("done_busy", int'(busy), 0);
        check("write_count", writes, 16);
        check("queue_drained", sb.size(), 0);
    endtask

    initial begin
        fillAll(8'd0, 8'd0);
        repeat (2) tick();
        check("rst_img_col", int'(oImageCol), 0);
        check("rst_img_row", int'(oImageRow), 0);
        check("rst_res_col", int'(oResultCol), 0);
        check("rst_res_row", int'(oResultRow), 0);
        check("rst_res_data", int'(oResultData), 0);
        check("rst_wren", int'(oResultWren), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_finished", int'(finished), 0);
        reset = 1'b1;
        tick();

        fillAll(8'd100, 8'd100);
        runPass(1'b0, 8'd0, -1);

        fillAll(8'd0, 8'd0);
        rom[5] = 8'd255;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                expImg[r*4+c] = 8'd28;
        runPass(1'b0, 8'd0, -1);

        fillAll(8'd0, 8'd0);
        rom[5]    = 8'd255;
        expImg[5] = 8'd255;
        runPass(1'b1, 8'd0, -1);

        fillAll(8'd255, 8'd255);
        runPass(1'b0, 8'd0, -1);

        fillAll(8'd100, 8'd255);
        runPass(1'b1, 8'd5, -1);

        fillAll(8'd100, 8'd0);
        runPass(1'b1, 8'd0, -1);

        fillAll(8'd0, 8'd0);
        runPass(1'b1, 8'd10, -1);

        // Abort a run on a write cycle, then restart from scratch
        fillAll(8'd100, 8'd100);
        pushExpected();
        iStart = 1'b1;
        tick();
        iStart = 1'b0;
        repeat (54) tick();
        check("pre_reset_wren", int'(oResultWren), 1);
        reset = 1'b0;
        #1;
        check("abort_wren", int'(oResultWren), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_finished", int'(finished), 0);
        sb.delete();
        writes = 0;
        repeat (5) tick();
        reset = 1'b1;
        tick();
        check("post_reset_writes", writes, 0);
        check("post_reset_finished", int'(finished), 0);
        runPass(1'b0, 8'd0, -1);

        // Start pulse while busy must be ignored
        runPass(1'b0, 8'd0, 30);

        repeat (3) tick();
        check("done_held", int'(finished), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
